reorder_buffer_mc: RTL



---
 rtl/rob_pkg.sv | 23 ++
 rtl/rob_commit_sel.sv | 46 ++++
 rtl/reorder_buffer_mc.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared definitions for the multi-port reorder buffer.
// Holds the opcode encoding, the branch value field positions, the branch
// redirect mask, and a helper that extracts a branch redirect target.
package rob_pkg;

  localparam logic [1:0] OP_REG    = 2'd0;
  localparam logic [1:0] OP_STORE  = 2'd1;
  localparam logic [1:0] OP_BRANCH = 2'd2;
  localparam logic [1:0] OP_JALR   = 2'd3;

  // Branch value layout: [31 -: LOCAL_WIDTH] predictor index,
  // [17:2] alternate PC, [1] predicted direction, [0] actual direction.
  localparam int BR_ACT_BIT  = 0;
  localparam int BR_PRED_BIT = 1;

  // Keeps only the alternate-PC field, word aligned.
  localparam logic [31:0] REDIRECT_MASK = 32'h0003FFFC;

  function automatic logic [31:0] redirect_pc(input logic [31:0] v);
    return v & REDIRECT_MASK;
  endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Commit lane selection for the reorder buffer (purely combinational).
// Inputs : head (h0_*) and head+1 (h1_*) entry fields.
// Outputs: lane_en[1:0] lane commit enables, flush/flush_pc redirect decision.
module rob_commit_sel
  import rob_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2
) (
  input  logic        h0_busy,
  input  logic        h0_ready,
  input  logic [1:0]  h0_op,
  input  logic [31:0] h0_value,
  input  logic [31:0] h0_target,
  input  logic [31:0] h0_pred,
  input  logic        h1_busy,
  input  logic        h1_ready,
  input  logic [1:0]  h1_op,
  output logic [1:0]  lane_en,
  output logic        flush,
  output logic [31:0] flush_pc
);

  always_comb begin
    lane_en  = '0;
    flush    = 1'b0;
    flush_pc = '0;
    if (h0_busy && h0_ready) begin
      lane_en[0] = 1'b1;
      if (h0_op == OP_BRANCH && h0_value[BR_PRED_BIT] != h0_value[BR_ACT_BIT]) begin
        flush    = 1'b1;
        flush_pc = redirect_pc(h0_value);
      end
      if (h0_op == OP_JALR && h0_target != h0_pred) begin
        flush    = 1'b1;
        flush_pc = h0_target;
      end
      // Second lane only rides behind a plain REG commit, so a cycle never
      // carries more than one store, one branch or one flush.
      if (COMMIT_WIDTH == 2 && h0_op == OP_REG && h1_busy && h1_ready &&
          (h1_op == OP_REG || h1_op == OP_STORE)) begin
        lane_en[1] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reorder_buffer_mc.sv
// Multi-port reorder buffer: in-order issue, WB_PORTS write-back channels,
// up to COMMIT_WIDTH commits per cycle, branch/JALR misprediction flush.
// Ports: clk_in/rst_in/rdy_in; issue bundle; packed write-back channels;
// per-lane register commit (reg_*), store commit (lsb_*), predictor update,
// flush (clear_signal/correct_pc), rear tag, operand lookups, full, count.
module reorder_buffer_mc
  import rob_pkg::*;
#(
  parameter int ROB_WIDTH    = 4,
  parameter int WB_PORTS     = 3,
  parameter int COMMIT_WIDTH = 2,
  parameter int LOCAL_WIDTH  = 6
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          issue_signal,
  input  logic [1:0]                    issue_opcode,
  input  logic                          issue_value_ready,
  input  logic [31:0]                   issue_value,
  input  logic [4:0]                    issue_rd_id,
  input  logic [31:0]                   issue_pc_prediction,
  input  logic [WB_PORTS-1:0]           wb_valid,
  input  logic [WB_PORTS*ROB_WIDTH-1:0] wb_tag,
  input  logic [WB_PORTS*32-1:0]        wb_value,
  output logic [COMMIT_WIDTH-1:0]       reg_done,
  output logic [COMMIT_WIDTH*32-1:0]    reg_value,
  output logic [COMMIT_WIDTH*5-1:0]     reg_id,
  output logic [COMMIT_WIDTH*ROB_WIDTH-1:0] reg_tag,
  output logic                          lsb_done,
  output logic [ROB_WIDTH-1:0]          lsb_tag,
  output logic                          predictor_signal,
  output logic                          predictor_branch,
  output logic [LOCAL_WIDTH-1:0]        predictor_addr,
  output logic                          clear_signal,
  output logic [31:0]                   correct_pc,
  output logic [ROB_WIDTH-1:0]          rob_tag,
  input  logic [ROB_WIDTH-1:0]          rob_tag_rs1,
  input  logic [ROB_WIDTH-1:0]          rob_tag_rs2,
  output logic [31:0]                   rob_value_rs1,
  output logic [31:0]                   rob_value_rs2,
  output logic                          rob_ready_rs1,
  output logic                          rob_ready_rs2,
  output logic                          full,
  output logic [ROB_WIDTH:0]            count
);

  localparam int ROB_SIZE = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] CNT_FULL = (ROB_WIDTH+1)'(ROB_SIZE);

  logic [ROB_WIDTH-1:0] front_q, front_d, rear_q, rear_d;
  logic [ROB_WIDTH:0]   count_q, count_d;
  logic                 busy_q   [ROB_SIZE];
  logic                 busy_d   [ROB_SIZE];
  logic                 ready_q  [ROB_SIZE];
  logic                 ready_d  [ROB_SIZE];
  logic [1:0]           op_q     [ROB_SIZE];
  logic [1:0]           op_d     [ROB_SIZE];
  logic [31:0]          value_q  [ROB_SIZE];
  logic [31:0]          value_d  [ROB_SIZE];
  logic [4:0]           rd_q     [ROB_SIZE];
  logic [4:0]           rd_d     [ROB_SIZE];
  logic [31:0]          pred_q   [ROB_SIZE];
  logic [31:0]          pred_d   [ROB_SIZE];
  logic [31:0]          target_q [ROB_SIZE];
  logic [31:0]          target_d [ROB_SIZE];

  logic [COMMIT_WIDTH-1:0]           reg_done_q, reg_done_d;
  logic [COMMIT_WIDTH*32-1:0]        reg_value_q, reg_value_d;
  logic [COMMIT_WIDTH*5-1:0]         reg_id_q, reg_id_d;
  logic [COMMIT_WIDTH*ROB_WIDTH-1:0] reg_tag_q, reg_tag_d;
  logic                              lsb_done_q, lsb_done_d;
  logic [ROB_WIDTH-1:0]              lsb_tag_q, lsb_tag_d;
  logic                              pred_sig_q, pred_sig_d;
  logic                              pred_br_q, pred_br_d;
  logic [LOCAL_WIDTH-1:0]            pred_addr_q, pred_addr_d;
  logic                              clear_q, clear_d;
  logic [31:0]                       correct_pc_q, correct_pc_d;

  logic [ROB_WIDTH-1:0] head1;
  logic [1:0]           lane_en;
  logic                 flush;
  logic [31:0]          flush_pc;
  logic                 do_issue;

  assign head1 = front_q + 1'b1;

  rob_commit_sel #(.COMMIT_WIDTH(COMMIT_WIDTH)) u_sel (
    .h0_busy  (busy_q[front_q]),
    .h0_ready (ready_q[front_q]),
    .h0_op    (op_q[front_q]),
    .h0_value (value_q[front_q]),
    .h0_target(target_q[front_q]),
    .h0_pred  (pred_q[front_q]),
    .h1_busy  (busy_q[head1]),
    .h1_ready (ready_q[head1]),
    .h1_op    (op_q[head1]),
    .lane_en  (lane_en),
    .flush    (flush),
    .flush_pc (flush_pc)
  );

  // A full buffer still accepts an issue when the head retires this cycle.
  assign do_issue = issue_signal && ((count_q != CNT_FULL) || lane_en[0]);

  always_comb begin
    logic [ROB_WIDTH-1:0] idx;
    idx          = '0;
    front_d      = front_q;
    rear_d       = rear_q;
    count_d      = count_q;
    busy_d       = busy_q;
    ready_d      = ready_q;
    op_d         = op_q;
    value_d      = value_q;
    rd_d         = rd_q;
    pred_d       = pred_q;
    target_d     = target_q;
    reg_done_d   = '0;
    reg_value_d  = reg_value_q;
    reg_id_d     = reg_id_q;
    reg_tag_d    = reg_tag_q;
    lsb_done_d   = 1'b0;
    lsb_tag_d    = lsb_tag_q;
    pred_sig_d   = 1'b0;
    pred_br_d    = pred_br_q;
    pred_addr_d  = pred_addr_q;
    clear_d      = 1'b0;
    correct_pc_d = correct_pc_q;

    if (clear_q) begin
      // Pending flush: behave exactly like reset on this edge.
      front_d      = '0;
      rear_d       = '0;
      count_d      = '0;
      reg_value_d  = '0;
      reg_id_d     = '0;
      reg_tag_d    = '0;
      lsb_tag_d    = '0;
      pred_br_d    = 1'b0;
      pred_addr_d  = '0;
      correct_pc_d = '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        busy_d[i]  = 1'b0;
        ready_d[i] = 1'b0;
      end
    end else begin
      for (int l = 0; l < COMMIT_WIDTH; l++) begin
        idx = front_q + ROB_WIDTH'(l);
        if (lane_en[l]) begin
          busy_d[idx]  = 1'b0;
          ready_d[idx] = 1'b0;
          case (op_q[idx])
            OP_STORE: begin
              lsb_done_d = 1'b1;
              lsb_tag_d  = idx;
            end
            OP_BRANCH: begin
              pred_sig_d  = 1'b1;
              pred_br_d   = value_q[idx][BR_ACT_BIT];
              pred_addr_d = value_q[idx][31 -: LOCAL_WIDTH];
            end
            default: begin
              reg_done_d[l]                   = 1'b1;
              reg_value_d[l*32 +: 32]         = value_q[idx];
              reg_id_d[l*5 +: 5]              = rd_q[idx];
              reg_tag_d[l*ROB_WIDTH +: ROB_WIDTH] = idx;
            end
          endcase
        end
      end
      if (flush) begin
        clear_d      = 1'b1;
        correct_pc_d = flush_pc;
      end
      front_d = front_q + ROB_WIDTH'(lane_en[0]) + ROB_WIDTH'(lane_en[1]);

      // Walk channels high to low so the lowest-indexed channel wins a tag.
      for (int k = WB_PORTS - 1; k >= 0; k--) begin
        idx = wb_tag[k*ROB_WIDTH +: ROB_WIDTH];
        if (wb_valid[k] && busy_q[idx] && !ready_q[idx]) begin
          ready_d[idx] = 1'b1;
          case (op_q[idx])
            OP_BRANCH: value_d[idx][BR_ACT_BIT] = wb_value[k*32];
            OP_JALR:   target_d[idx] = wb_value[k*32 +: 32];
            default:   value_d[idx]  = wb_value[k*32 +: 32];
          endcase
        end
      end

      // Issue is applied last so it overrides commit and write-back on rear.
      if (do_issue) begin
        busy_d[rear_q]  = 1'b1;
        ready_d[rear_q] = issue_value_ready;
        op_d[rear_q]    = issue_opcode;
        value_d[rear_q] = issue_value;
        rd_d[rear_q]    = issue_rd_id;
        pred_d[rear_q]  = issue_pc_prediction;
        rear_d          = rear_q + 1'b1;
      end
      count_d = count_q + (ROB_WIDTH+1)'(do_issue)
              - (ROB_WIDTH+1)'(lane_en[0]) - (ROB_WIDTH+1)'(lane_en[1]);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      front_q      <= '0;
      rear_q       <= '0;
      count_q      <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        busy_q[i]  <= 1'b0;
        ready_q[i] <= 1'b0;
      end
      reg_done_q   <= '0;
      reg_value_q  <= '0;
      reg_id_q     <= '0;
      reg_tag_q    <= '0;
      lsb_done_q   <= 1'b0;
      lsb_tag_q    <= '0;
      pred_sig_q   <= 1'b0;
      pred_br_q    <= 1'b0;
      pred_addr_q  <= '0;
      clear_q      <= 1'b0;
      correct_pc_q <= '0;
    end else if (rdy_in) begin
      front_q      <= front_d;
      rear_q       <= rear_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      reg_done_q   <= reg_done_d;
      reg_value_q  <= reg_value_d;
      reg_id_q     <= reg_id_d;
      reg_tag_q    <= reg_tag_d;
      lsb_done_q   <= lsb_done_d;
      lsb_tag_q    <= lsb_tag_d;
      pred_sig_q   <= pred_sig_d;
      pred_br_q    <= pred_br_d;
      pred_addr_q  <= pred_addr_d;
      clear_q      <= clear_d;
      correct_pc_q <= correct_pc_d;
    end
  end

  // Entry payload is qualified by busy, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      op_q     <= op_d;
      value_q  <= value_d;
      rd_q     <= rd_d;
      pred_q   <= pred_d;
      target_q <= target_d;
    end
  end

  assign reg_done         = reg_done_q;
  assign reg_value        = reg_value_q;
  assign reg_id           = reg_id_q;
  assign reg_tag          = reg_tag_q;
  assign lsb_done         = lsb_done_q;
  assign lsb_tag          = lsb_tag_q;
  assign predictor_signal = pred_sig_q;
  assign predictor_branch = pred_br_q;
  assign predictor_addr   = pred_addr_q;
  assign clear_signal     = clear_q;
  assign correct_pc       = correct_pc_q;
  assign rob_tag          = rear_q;
  assign count            = count_q;
  assign full             = (count_q == CNT_FULL) ||
                            (count_q == CNT_FULL - 1'b1 && issue_signal);
  assign rob_value_rs1    = value_q[rob_tag_rs1];
  assign rob_value_rs2    = value_q[rob_tag_rs2];
  assign rob_ready_rs1    = busy_q[rob_tag_rs1] && ready_q[rob_tag_rs1];
  assign rob_ready_rs2    = busy_q[rob_tag_rs2] && ready_q[rob_tag_rs2];

endmodule
